lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
Load/store stage directly downstream of the execute unit. Takes the ALU result (address or pass-through value), store data and memory-op controls from EXU, and issues one word-aligned request on a valid/ready memory port. It aligns byte lanes, sign/zero-extends load data and hands the writeback value to WBU over a valid/ready handshake. Non-memory instructions pass through with one cycle of latency; a response timeout converts a hung bus into an error.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; lane logic assumes 4 bytes)
- TIMEOUT, 255, max cycles in WAIT before error; 0 disables the timeout
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EXU has an instruction
- in_ready  out  1  stage can accept
- in_alu  in  32  ALU result: address, or writeback value
- in_wdata  in  32  store data (rs2)
- in_memread  in  1  load
- in_memwrite  in  1  store; priority over in_memread
- in_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts
- out_data  out  32  writeback value
- out_err  out  1  misaligned, illegal op, bus error or timeout
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  {addr[31:2],2'b00}
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  high only in WAIT
- mem_resp_rdata  in  32  read word
- mem_resp_err  in  1  bus error

Behaviour:
- Reset: state IDLE; all outputs except in_ready = 0; timeout counter 0. in_ready = 1 after reset.
- FSM: IDLE, REQ, WAIT, DONE. in_ready = (state == IDLE).
- IDLE: on in_valid, latch all inputs.
  - No memory op -> DONE; out_data = in_alu, err = 0.
  - Memory op, legal and aligned -> REQ.
  - Otherwise -> DONE with out_data = 0, out_err = 1, and no bus request.
- Illegal ops: memop 011/110/111 on load; memop other than 000/001/010 on store.
- Misaligned: h/hu/sh with addr[0] = 1; w/sw with addr[1:0] != 0.
- REQ: mem_req_valid = 1; addr, wen, wdata and wstrb held stable until mem_req_ready. On handshake -> WAIT, counter cleared.
- WAIT: mem_resp_ready = 1. On mem_resp_valid -> DONE, out_err = mem_resp_err.
  - Without a response, counter increments each cycle. If TIMEOUT != 0 and counter == TIMEOUT - 1 -> DONE, out_err = 1, out_data = 0.
- DONE: out_valid = 1, and out_data/out_err are held. On out_ready -> IDLE. The next instruction is accepted the cycle after.
- Minimum latency with zero-wait memory: accept edge t0, REQ t1, WAIT t2 with response, out_valid at t3. Pass-through: out_valid at t1.
- Store lanes, with s = addr[1:0]:
  - wdata = in_wdata << 8*s.
  - wstrb = 0001 (sb), 0011 (sh) or 1111 (sw), shifted left by s.
- Store writeback: out_data = 0, out_err = resp err.
- Load extraction: r = rdata >> 8*s.
  - b: sign-extend r[7:0]; h: sign-extend r[15:0]; w: r.
  - bu/hu: zero-extend the same bits.
- Loads issue wstrb = 0 and wdata = 0.
- in_memread and in_memwrite both set: treated as a store.
- A response arriving outside WAIT is not acknowledged (mem_resp_ready = 0) and is ignored.
- Reset mid-operation: next edge forces IDLE and drops mem_req_valid/mem_resp_ready. The in-flight transaction is abandoned; the memory side must tolerate this.

Test Plan:
- Pass-through: in_alu = 0x1234_5678, no mem op, out_ready = 1 -> out_valid next cycle, out_data = 0x12345678, err 0, no mem_req_valid ever.
- lb at 0x8000_0003, rdata 0x80AA_BBCC, zero-wait -> mem_req_addr 0x8000_0000, out_data 0xFFFF_FF80 at t3. Same access as lbu -> 0x0000_0080.
- sh at 0x8000_0002, in_wdata 0x0000_1234 -> wen 1, wdata 0x1234_0000, wstrb 1100. mem_req_ready low 3 cycles -> request fields stable throughout; out_data 0, err 0.
- lw at 0x8000_0001 -> no request, out_valid next cycle, out_err 1, out_data 0. lh at 0x8000_0002 with rdata 0x8001_0000 -> 0xFFFF_8001.
- TIMEOUT = 4, no response -> out_err 1 after 4 WAIT cycles. A late mem_resp_valid in IDLE -> mem_resp_ready stays 0. With mem_resp_err = 1 -> out_err 1.
- Reset asserted during WAIT -> next cycle IDLE, in_ready 1, all handshake outputs 0. Backpressure with out_ready low 5 cycles in DONE -> out_data held, in_ready 0.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage; issues one word-aligned memory request per instruction,
// aligns byte lanes, extends load data and hands the result to writeback.
module lsu_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [2:0]        in_memop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  input  logic              mem_resp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wd, data_q, data_n, r, ld;
  logic [2:0] op;
  logic st, err_q, err_n, req, wr, in_mem, bad;
  logic [CNT_W-1:0] cnt, cnt_n;
  assign in_mem = in_memread | in_memwrite;
  // illegal encodings for the op kind, or an access not naturally aligned
  assign bad = (in_memwrite ? (in_memop[2] || in_memop[1:0] == 2'b11)
                            : (in_memop == 3'b011 || in_memop[2:1] == 2'b11))
            || (in_memop[1:0] == 2'b01 && in_alu[0])
            || (in_memop[1:0] == 2'b10 && in_alu[1:0] != 2'b00);
  assign r = mem_resp_rdata >> {addr[1:0], 3'b000};
  assign ld = op[1:0] == 2'b00 ? {{24{~op[2] & r[7]}}, r[7:0]}
            : op[1:0] == 2'b01 ? {{16{~op[2] & r[15]}}, r[15:0]} : r;
  assign req = state == REQ;
  assign wr = req & st;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_data = data_q;
  assign out_err = err_q;
  assign mem_req_valid = req;
  assign mem_req_addr = req ? {addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wen = wr;
  assign mem_req_wdata = wr ? wd << {addr[1:0], 3'b000} : '0;
  assign mem_req_wstrb = wr ? (op[1:0] == 2'b00 ? 4'b0001 : op[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << addr[1:0] : 4'b0000;
  assign mem_resp_ready = state == WAIT;
  always_comb begin
    state_n = state;
    data_n = data_q;
    err_n = err_q;
    cnt_n = cnt;
    case (state)
      IDLE: if (in_valid) begin
        state_n = in_mem && !bad ? REQ : DONE;
        data_n = in_mem ? '0 : DATA_W'(in_alu);
        err_n = in_mem && bad;
      end
      REQ: if (mem_req_ready) begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: if (mem_resp_valid) begin
        state_n = DONE;
        data_n = st ? '0 : ld;
        err_n = mem_resp_err;
      end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
        state_n = DONE;
        data_n = '0;
        err_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      default: if (out_ready) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
      addr <= '0;
      wd <= '0;
      op <= '0;
      st <= 1'b0;
    end else begin
      state <= state_n;
      data_q <= data_n;
      err_q <= err_n;
      cnt <= cnt_n;
      if (state == IDLE && in_valid) begin
        addr <= in_alu;
        wd <= in_wdata;
        op <= in_memop;
        st <= in_memwrite;
      end
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed and randomized checks of lsu_stage against a behavioural model.
module tb_lsu_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_memread = 0, in_memwrite = 0;
  logic [31:0] in_alu = 0, in_wdata = 0, out_data, mem_req_addr, mem_req_wdata, mem_resp_rdata = 0;
  logic [2:0] in_memop = 0;
  logic out_valid, out_ready = 0, out_err, mem_req_valid, mem_req_ready = 0, mem_req_wen;
  logic [3:0] mem_req_wstrb;
  logic mem_resp_valid = 0, mem_resp_ready, mem_resp_err = 0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  lsu_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu),
    .in_wdata(in_wdata), .in_memread(in_memread), .in_memwrite(in_memwrite), .in_memop(in_memop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err));

  // Reference: derived from the access rules with integer arithmetic.
  task automatic model(input logic [31:0] alu, wd, input logic rd, wrt, input logic [2:0] op,
                       input logic [31:0] rdata, input logic rerr, input logic tmo,
                       output logic req, output logic [31:0] addr, output logic wen,
                       output logic [31:0] wdata, output logic [3:0] strb,
                       output logic [31:0] d, output logic e);
    int s, size;
    logic legal;
    longint v, half;
    s = alu % 4;
    size = (op % 4 == 0) ? 1 : (op % 4 == 1) ? 2 : 4;
    legal = wrt ? (op <= 2) : (op <= 2 || op == 4 || op == 5);
    req = 0; addr = 0; wen = 0; wdata = 0; strb = 0;
    if (!rd && !wrt) begin d = alu; e = 0; end
    else if (!legal || (alu % size) != 0) begin d = 0; e = 1; end
    else begin
      req = 1;
      addr = alu - s;
      wen = wrt;
      if (wrt) begin
        wdata = 32'((longint'(wd) << (8 * s)) & 64'hFFFF_FFFF);
        strb = 4'(((1 << size) - 1) << s);
        d = 0;
      end else begin
        v = (longint'(rdata) >> (8 * s)) % (longint'(1) << (8 * size));
        half = longint'(1) << (8 * size - 1);
        if (op < 4 && v >= half) v = v - 2 * half;
        d = 32'(v);
      end
      e = tmo ? 1'b1 : rerr;
      if (tmo) d = 0;
    end
  endtask

  // Drives one instruction through and reports what the DUT did.
  task automatic do_op(input string name, input logic [31:0] alu, wd, input logic rd, wrt,
                       input logic [2:0] op, input logic [31:0] rdata, input logic rerr,
                       input int req_wait, resp_wait, input logic no_resp, input int hold,
                       output logic [31:0] d, output logic e, output logic issued,
                       output logic [31:0] ra, rwd, output logic [3:0] rs, output logic rw,
                       output logic stable, output int lat, output int waits, output logic held);
    int k;
    logic done;
    issued = 0; stable = 1; held = 1; k = 0; waits = 0; lat = 0; done = 0;
    d = 'x; e = 1'bx; ra = 0; rwd = 0; rs = 0; rw = 0;
    @(negedge clk);
    in_valid = 1; in_alu = alu; in_wdata = wd; in_memread = rd; in_memwrite = wrt; in_memop = op;
    for (int i = 1; i <= 100 && !done; i++) begin
      @(negedge clk);
      in_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
      if (out_valid) begin
        d = out_data; e = out_err; lat = i;
        repeat (hold) begin
          @(negedge clk);
          if (out_data !== d || out_err !== e || in_ready !== 1'b0 || out_valid !== 1'b1) held = 0;
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        done = 1;
      end else if (mem_req_valid) begin
        if (!issued) begin
          issued = 1; ra = mem_req_addr; rwd = mem_req_wdata; rs = mem_req_wstrb; rw = mem_req_wen;
        end else if (mem_req_addr !== ra || mem_req_wdata !== rwd || mem_req_wstrb !== rs || mem_req_wen !== rw)
          stable = 0;
        mem_req_ready = (k >= req_wait);
        k++;
      end else if (mem_resp_ready) begin
        if (!no_resp && waits >= resp_wait) begin
          mem_resp_valid = 1; mem_resp_rdata = rdata; mem_resp_err = rerr;
        end
        waits++;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s: out_valid never seen within 100 cycles", name);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if ({out_valid, mem_req_valid, mem_resp_ready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_handshakes: got %b want 000", {out_valid, mem_req_valid, mem_resp_ready});
    end
    if (out_data !== 32'h0 || out_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_out: got %h/%b want 0/0", out_data, out_err);
    end
    if ({mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen} !== 69'h0) begin
      miscompares++; $display("FAIL reset_req_fields: got %h %h %b %b want zeros", mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen);
    end
    rst = 0;
  endtask

  task automatic test_passthrough;
    logic [31:0] d, ra, rwd; logic e, iss, rw, stb, hd; logic [3:0] rs; int lat, w;
    do_op("pass", 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors += 2;
    if (d !== 32'h1234_5678 || e !== 1'b0) begin miscompares++; $display("FAIL pass_data: got %h/%b want 12345678/0", d, e); end
    if (iss !== 1'b0 || lat != 1) begin miscompares++; $display("FAIL pass_timing: req %b lat %0d want 0/1", iss, lat); end
  endtask

  task automatic test_load;
    logic [31:0] d, ra, rwd; logic e, iss, rw, stb, hd; logic [3:0] rs; int lat, w;
    do_op("lb", 32'h8000_0003, 0, 1, 0, 3'b000, 32'h80AA_BBCC, 0, 0, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors += 3;
    if (ra !== 32'h8000_0000 || rw !== 1'b0 || rs !== 4'b0 || rwd !== 32'h0) begin
      miscompares++; $display("FAIL lb_req: addr %h wen %b strb %b wdata %h want 80000000/0/0000/0", ra, rw, rs, rwd);
    end
    if (d !== 32'hFFFF_FF80 || e !== 1'b0) begin miscompares++; $display("FAIL lb_data: got %h/%b want ffffff80/0", d, e); end
    if (lat != 3) begin miscompares++; $display("FAIL lb_latency: got %0d want 3", lat); end
    do_op("lbu", 32'h8000_0003, 0, 1, 0, 3'b100, 32'h80AA_BBCC, 0, 0, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors++;
    if (d !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data: got %h want 00000080", d); end
    do_op("lh", 32'h8000_0002, 0, 1, 0, 3'b001, 32'h8001_0000, 0, 0, 1, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors++;
    if (d !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_data: got %h want ffff8001", d); end
  endtask

  task automatic test_store;
    logic [31:0] d, ra, rwd; logic e, iss, rw, stb, hd; logic [3:0] rs; int lat, w;
    do_op("sh", 32'h8000_0002, 32'h0000_1234, 0, 1, 3'b001, 32'hFFFF_FFFF, 0, 3, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors += 3;
    if (rw !== 1'b1 || rwd !== 32'h1234_0000 || rs !== 4'b1100 || ra !== 32'h8000_0000) begin
      miscompares++; $display("FAIL sh_req: wen %b wdata %h strb %b addr %h want 1/12340000/1100/80000000", rw, rwd, rs, ra);
    end
    if (stb !== 1'b1) begin miscompares++; $display("FAIL sh_stable: request fields changed while stalled"); end
    if (d !== 32'h0 || e !== 1'b0) begin miscompares++; $display("FAIL sh_wb: got %h/%b want 0/0", d, e); end
  endtask

  task automatic test_misaligned;
    logic [31:0] d, ra, rwd; logic e, iss, rw, stb, hd; logic [3:0] rs; int lat, w;
    do_op("lw_mis", 32'h8000_0001, 0, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors += 2;
    if (iss !== 1'b0 || lat != 1) begin miscompares++; $display("FAIL lw_mis_timing: req %b lat %0d want 0/1", iss, lat); end
    if (d !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL lw_mis_out: got %h/%b want 0/1", d, e); end
    do_op("sb_illegal", 32'h0000_0100, 32'h55, 1, 1, 3'b100, 0, 0, 0, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors++;
    if (iss !== 1'b0 || e !== 1'b1 || d !== 32'h0) begin
      miscompares++; $display("FAIL store_illegal: req %b out %h/%b want 0 0/1", iss, d, e);
    end
  endtask

  task automatic test_timeout_err;
    logic [31:0] d, ra, rwd; logic e, iss, rw, stb, hd; logic [3:0] rs; int lat, w;
    do_op("tmo", 32'h0000_0040, 0, 1, 0, 3'b010, 0, 0, 0, 0, 1, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors += 2;
    if (d !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL timeout_out: got %h/%b want 0/1", d, e); end
    if (w != 4) begin miscompares++; $display("FAIL timeout_cycles: got %0d want 4", w); end
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_rdata = 32'h1111_1111;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (mem_resp_ready !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++; $display("FAIL late_resp: resp_ready %b out_valid %b in_ready %b want 0/0/1", mem_resp_ready, out_valid, in_ready);
      end
    end
    mem_resp_valid = 0;
    do_op("buserr", 32'h0000_0044, 0, 1, 0, 3'b010, 32'h7, 1, 0, 0, 0, 0, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL bus_err: got %b want 1", e); end
    mem_resp_err = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1; in_alu = 32'h0000_0100; in_memread = 1; in_memwrite = 0; in_memop = 3'b010;
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    vectors++;
    if (mem_resp_ready !== 1'b1) begin miscompares++; $display("FAIL mid_wait: resp_ready %b want 1", mem_resp_ready); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    vectors++;
    if ({in_ready, out_valid, mem_req_valid, mem_resp_ready} !== 4'b1000) begin
      miscompares++; $display("FAIL mid_reset: in_ready/out_valid/req/resp %b want 1000", {in_ready, out_valid, mem_req_valid, mem_resp_ready});
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d, ra, rwd; logic e, iss, rw, stb, hd; logic [3:0] rs; int lat, w;
    do_op("bp", 32'hCAFE_F00D, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 5, d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
    vectors += 2;
    if (hd !== 1'b1) begin miscompares++; $display("FAIL bp_hold: outputs changed or in_ready rose under backpressure"); end
    if (d !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL bp_data: got %h want cafef00d", d); end
  endtask

  task automatic test_random;
    logic [31:0] d, ra, rwd, alu, wd, rdata, xa, xwd, xd; logic e, iss, rw, stb, hd, rd, wrt, rerr, nr, xr, xw, xe;
    logic [3:0] rs, xs; logic [2:0] op; int lat, w;
    for (int n = 0; n < 80; n++) begin
      alu = $urandom; wd = $urandom; rdata = $urandom; op = 3'($urandom);
      rd = 1'($urandom); wrt = 1'($urandom); rerr = ($urandom_range(0, 5) == 0);
      nr = ($urandom_range(0, 7) == 0);
      do_op("rand", alu, wd, rd, wrt, op, rdata, rerr, $urandom_range(0, 2), $urandom_range(0, 3), nr, 0,
            d, e, iss, ra, rwd, rs, rw, stb, lat, w, hd);
      model(alu, wd, rd, wrt, op, rdata, rerr, nr, xr, xa, xw, xwd, xs, xd, xe);
      vectors++;
      if (iss !== xr || d !== xd || e !== xe || (xr && (ra !== xa || rw !== xw || rwd !== xwd || rs !== xs || stb !== 1'b1))) begin
        miscompares++;
        $display("FAIL rand[%0d] alu %h op %b rd %b wr %b: got req %b addr %h wen %b wd %h strb %b out %h/%b want req %b addr %h wen %b wd %h strb %b out %h/%b",
                 n, alu, op, rd, wrt, iss, ra, rw, rwd, rs, d, e, xr, xa, xw, xwd, xs, xd, xe);
      end
    end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_load;
    test_store;
    test_misaligned;
    test_timeout_err;
    test_reset_mid;
    test_backpressure;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
